cpu_oci_dct_sequencer: RTL

Sequencer for the Nios II OCI data-capture-trace (DCT) path. Packs 6-bit trace atoms from the CPU debug core into the 30-bit `dct_buffer` with its 4-bit `dct_count`, hands completed frames to trace memory over a valid/ready handshake, and runs the end-of-test drain that produces `test_ending` and `test_has_ended` for the OCI test bench. Sits between the CPU trace-atom source and the on-chip trace RAM writer.

---
 rtl/cpu_oci_dct_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/cpu_oci_dct_sequencer.sv
// cpu_oci_dct_sequencer
// Packs 6-bit CPU trace atoms into 5-atom DCT frames ({dct_count, dct_buffer}).
// Completed frames go to the trace RAM writer over a valid/ready output register.
// The end-of-test drain flushes any partial frame, then reports test_has_ended.
// Optional feature macro: DCT_IDLE_TIMEOUT_EN. When it is defined, a partial frame
// that sees TIMEOUT_CYCLES idle cycles is flushed without waiting for the drain.
module cpu_oci_dct_sequencer #(
    parameter int ADDR_W         = 7,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              atom_valid,
    input  logic [5:0]        atom_data,
    output logic              atom_ready,
    input  logic              end_req,
    output logic              tw_valid,
    input  logic              tw_ready,
    output logic [33:0]       tw_data,
    output logic [ADDR_W-1:0] tw_addr,
    output logic              tw_wrapped,
    output logic [29:0]       dct_buffer,
    output logic [3:0]        dct_count,
    output logic              test_ending,
    output logic              test_has_ended
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        ENDED   = 2'd2
    } state_e;

    state_e            state_q;
    logic              ending_q;
    logic              ended_q;

    logic [29:0]       buf_q, buf_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              tw_valid_q, tw_valid_d;
    logic [33:0]       tw_data_q, tw_data_d;
    logic [ADDR_W-1:0] tw_addr_q, tw_addr_d;
    logic              wrapped_q, wrapped_d;

    logic              flush_pending;
    logic              frame_full;
    logic              out_free;
    logic              do_transfer;
    logic              handshake;
    logic              accept;

`ifdef DCT_IDLE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0]     idle_q, idle_d;
    logic              timeout_hit;

    assign timeout_hit = (idle_q == TW'(TIMEOUT_CYCLES));
`else
    logic              timeout_unused;

    assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

    // A partial frame may leave the buffer while draining, or after an idle timeout when enabled.
    always_comb begin
        flush_pending = 1'b0;
        if (state_q == DRAIN) begin
            flush_pending = 1'b1;
        end
`ifdef DCT_IDLE_TIMEOUT_EN
        else if (state_q == COLLECT) begin
            flush_pending = timeout_hit;
        end
`endif
    end

    assign frame_full  = (cnt_q == 4'd5);
    assign out_free    = !tw_valid_q || tw_ready;
    assign do_transfer = (frame_full || (flush_pending && (cnt_q != 4'd0))) && out_free;
    assign handshake   = tw_valid_q && tw_ready;

    // Gating with reset_n keeps atom_ready low while reset is held.
    assign atom_ready  = reset_n && (state_q == COLLECT) && !frame_full && !do_transfer;
    assign accept      = atom_valid && atom_ready;

    // Packing buffer: a transfer empties it, otherwise an accepted atom lands in the next free slot.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        if (do_transfer) begin
            buf_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            for (int i = 0; i < 5; i++) begin
                if (cnt_q == 4'(i)) begin
                    buf_d[6*i +: 6] = atom_data;
                end
            end
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Output register: retire the held frame on handshake, then load a new one if a transfer fires.
    always_comb begin
        tw_valid_d = tw_valid_q;
        tw_data_d  = tw_data_q;
        tw_addr_d  = tw_addr_q;
        wrapped_d  = wrapped_q;
        if (handshake) begin
            tw_valid_d = 1'b0;
            tw_addr_d  = tw_addr_q + ADDR_W'(1);
            if (&tw_addr_q) begin
                wrapped_d = 1'b1;
            end
        end
        if (do_transfer) begin
            tw_valid_d = 1'b1;
            tw_data_d  = {cnt_q, buf_q};
        end
    end

    // Datapath registers; reset discards both the partial buffer and any held frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_q      <= '0;
            cnt_q      <= '0;
            tw_valid_q <= 1'b0;
            tw_data_q  <= '0;
            tw_addr_q  <= '0;
            wrapped_q  <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            tw_valid_q <= tw_valid_d;
            tw_data_q  <= tw_data_d;
            tw_addr_q  <= tw_addr_d;
            wrapped_q  <= wrapped_d;
        end
    end

`ifdef DCT_IDLE_TIMEOUT_EN
    // Idle counter: restarts on every accept or transfer, counts while a partial frame sits idle.
    always_comb begin
        idle_d = idle_q;
        if ((state_q != COLLECT) || do_transfer || accept) begin
            idle_d = '0;
        end else if ((cnt_q != 4'd0) && !timeout_hit) begin
            idle_d = idle_q + TW'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`endif

    // Test-end FSM; ENDED is left only through reset, and the status flags are registered with the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= COLLECT;
            ending_q <= 1'b0;
            ended_q  <= 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (end_req) begin
                        state_q  <= DRAIN;
                        ending_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if ((cnt_q == 4'd0) && !tw_valid_q) begin
                        state_q  <= ENDED;
                        ending_q <= 1'b0;
                        ended_q  <= 1'b1;
                    end
                end
                ENDED: begin
                end
                default: begin
                    state_q  <= COLLECT;
                    ending_q <= 1'b0;
                    ended_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tw_valid       = tw_valid_q;
    assign tw_data        = tw_data_q;
    assign tw_addr        = tw_addr_q;
    assign tw_wrapped     = wrapped_q;
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign test_ending    = ending_q;
    assign test_has_ended = ended_q;

endmodule
